// File: rtl/btn_rst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_rst_pkg
// Purpose  : Shared debounce state encoding and 50 MHz default timing.
// Revision : 1.0  initial release
// ============================================================================
package btn_rst_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_e;

   localparam int C_SYNC_STAGES       = 2;
   localparam int C_DEBOUNCE_CYCLES   = 250000;     // 5 ms
   localparam int C_RST_HOLD_CYCLES   = 16;
   localparam int C_LONG_PRESS_CYCLES = 100000000;  // 2 s

endpackage : btn_rst_pkg
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_ff
// Purpose  : Multi-flop synchronizer for a single asynchronous input.
// Revision : 1.0  initial release
// ============================================================================
module sync_ff #(
   parameter int   DEPTH   = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [DEPTH-1:0] r_chain;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_chain <= {DEPTH{RST_VAL}};
      end else begin
         r_chain <= {r_chain[DEPTH-2:0], d_i};
      end
   end

   assign q_o = r_chain[DEPTH-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/btn_rst_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_rst_conditioner
// Purpose  : Pushbutton -> synchronizer -> debounce FSM -> stretched core reset.
//            Define BTN_RST_LONG_PRESS_EN to add the long-press pulse.
// Revision : 1.0  initial release
// ============================================================================
module btn_rst_conditioner
   import btn_rst_pkg::*;
#(
   parameter int SYNC_STAGES       = C_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES   = C_DEBOUNCE_CYCLES,
   parameter int RST_HOLD_CYCLES   = C_RST_HOLD_CYCLES
`ifdef BTN_RST_LONG_PRESS_EN
   ,
   parameter int LONG_PRESS_CYCLES = C_LONG_PRESS_CYCLES
`endif
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_ni,
   output logic rst_no,
   output logic pressed_o,
   output logic press_o,
   output logic release_o,
   output logic long_press_o
);

   localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);

   logic              w_s;
   btn_state_e        r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [HOLD_W-1:0] r_hold, w_hold_nxt;
   logic              w_press_nxt, w_release_nxt, w_pressed_nxt;
   logic              r_boot, r_pressed, r_press, r_release, r_rst_n;

   sync_ff #(
      .DEPTH   (SYNC_STAGES),
      .RST_VAL (1'b1)
   ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (btn_ni),
      .q_o    (w_s)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= RELEASED;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      case (r_state)
         RELEASED: begin
            if (!w_s) begin
               w_state_nxt = PRESS_WAIT;
               w_cnt_nxt   = '0;
            end
         end
         PRESS_WAIT: begin
            if (w_s) begin
               w_state_nxt = RELEASED;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               w_state_nxt = PRESSED;
               w_press_nxt = 1'b1;
            end else if (r_cnt != CNT_W'(DEBOUNCE_CYCLES)) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (w_s) begin
               w_state_nxt = RELEASE_WAIT;
               w_cnt_nxt   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (!w_s) begin
               w_state_nxt = PRESSED;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               w_state_nxt   = RELEASED;
               w_release_nxt = 1'b1;
            end else if (r_cnt != CNT_W'(DEBOUNCE_CYCLES)) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = RELEASED;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // r_boot marks the first edge after rst_ni rises, which loads the hold window.
   always_comb begin
      w_hold_nxt = r_hold;
      if (r_boot || w_release_nxt) begin
         w_hold_nxt = HOLD_W'(RST_HOLD_CYCLES);
      end else if (r_hold != '0) begin
         w_hold_nxt = r_hold - 1'b1;
      end
   end

   assign w_pressed_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_WAIT);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_boot    <= 1'b1;
         r_hold    <= '0;
         r_pressed <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_rst_n   <= 1'b0;
      end else begin
         r_boot    <= 1'b0;
         r_hold    <= w_hold_nxt;
         r_pressed <= w_pressed_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
         r_rst_n   <= !w_pressed_nxt && (w_hold_nxt == '0);
      end
   end

   assign rst_no    = r_rst_n;
   assign pressed_o = r_pressed;
   assign press_o   = r_press;
   assign release_o = r_release;

`ifdef BTN_RST_LONG_PRESS_EN
   localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);

   logic [LP_W-1:0] r_lp_cnt;
   logic            r_long;
   logic            w_lp_fire;

   // Saturation at LONG_PRESS_CYCLES is what prevents a second pulse.
   assign w_lp_fire = (r_state == PRESSED) && (r_lp_cnt == LP_W'(LONG_PRESS_CYCLES - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_lp_cnt <= '0;
         r_long   <= 1'b0;
      end else begin
         r_long <= w_lp_fire;
         if (!w_pressed_nxt) begin
            r_lp_cnt <= '0;
         end else if ((r_state == PRESSED) && (r_lp_cnt != LP_W'(LONG_PRESS_CYCLES))) begin
            r_lp_cnt <= r_lp_cnt + 1'b1;
         end
      end
   end

   assign long_press_o = r_long;
`else
   assign long_press_o = 1'b0;
`endif

endmodule : btn_rst_conditioner
`default_nettype wire

// File: tb/tb_btn_rst_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_rst_conditioner
// Purpose  : Directed scoreboard bench for btn_rst_conditioner.
// Revision : 1.0  initial release
// ============================================================================
module tb_btn_rst_conditioner;

   localparam int SYNC = 2;
   localparam int DEB  = 8;
   localparam int HOLD = 4;
   localparam int LAT  = 1 + SYNC + DEB;   // drive cycle -> press/release pulse cycle
`ifdef BTN_RST_LONG_PRESS_EN
   localparam int LP   = 20;
`endif

   logic clk_i = 1'b0;
   logic rst_ni, btn_ni;
   logic rst_no, pressed_o, press_o, release_o, long_press_o;
   logic [4:0] obs;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   // exp vector: {rst_no, pressed_o, press_o, release_o, long_press_o}
   typedef struct {
      string      tag;
      int         cyc;
      logic [4:0] exp;
   } exp_t;

   exp_t sb[$];

   btn_rst_conditioner #(
      .SYNC_STAGES       (SYNC),
      .DEBOUNCE_CYCLES   (DEB),
      .RST_HOLD_CYCLES   (HOLD)
`ifdef BTN_RST_LONG_PRESS_EN
      ,
      .LONG_PRESS_CYCLES (LP)
`endif
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .btn_ni       (btn_ni),
      .rst_no       (rst_no),
      .pressed_o    (pressed_o),
      .press_o      (press_o),
      .release_o    (release_o),
      .long_press_o (long_press_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   assign obs = {rst_no, pressed_o, press_o, release_o, long_press_o};

   always @(negedge clk_i) begin
      exp_t e;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         checks++;
         assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed=%b expected=%b", e.tag, cyc, obs, e.exp);
         end
      end else begin
         checks++;
         assert (obs[2:0] === 3'b000) else begin
            errors++;
            $error("FAIL unexpected_pulse cyc=%0d: observed=%b expected=000", cyc, obs[2:0]);
         end
      end
   end

   task automatic push_exp(input string tag, input int c, input logic [4:0] v);
      exp_t e;
      e.tag = tag;
      e.cyc = c;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t, p, r, r1, p2, r2;
      rst_ni = 1'b0;
      btn_ni = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;

      checks++;
      assert ({rst_no, pressed_o} === 2'b00) else begin
         errors++;
         $error("FAIL reset_state: observed=%b expected=00", {rst_no, pressed_o});
      end

      // Reset release with the button idle
      t = cyc;
      push_exp("boot_hold", t + HOLD,     5'b00000);
      push_exp("boot_rise", t + HOLD + 1, 5'b10000);
      rst_ni = 1'b1;
      wait_until(t + 10);

      // Clean press held 30 cycles, then release
      t = cyc;
      btn_ni = 1'b0;
      p = t + LAT;
      push_exp("pre_press", p - 1, 5'b10000);
      push_exp("press",     p,     5'b01100);
      push_exp("press_end", p + 1, 5'b01000);
`ifdef BTN_RST_LONG_PRESS_EN
      push_exp("long_clean", p + LP, 5'b01001);
`endif
      wait_until(t + 30);
      btn_ni = 1'b1;
      r = cyc + LAT;
      push_exp("rel_wait",  r - 1,    5'b01000);
      push_exp("release",   r,        5'b00010);
      push_exp("hold_last", r + HOLD - 1, 5'b00000);
      push_exp("hold_rise", r + HOLD, 5'b10000);
      wait_until(r + HOLD + 5);

      // Bounce: low 5, high 2, low 5, high
      btn_ni = 1'b0;
      wait_until(cyc + 5);
      btn_ni = 1'b1;
      wait_until(cyc + 2);
      btn_ni = 1'b0;
      wait_until(cyc + 5);
      btn_ni = 1'b1;
      t = cyc;
      push_exp("bounce_idle",    t + 3,       5'b10000);
      push_exp("bounce_settled", t + LAT + 5, 5'b10000);
      wait_until(t + LAT + 8);

      // Re-press two cycles after release_o
      t = cyc;
      btn_ni = 1'b0;
      push_exp("press1", t + LAT, 5'b01100);
      wait_until(t + 15);
      btn_ni = 1'b1;
      r1 = cyc + LAT;
      push_exp("release1", r1,     5'b00010);
      push_exp("hold1",    r1 + 1, 5'b00000);
      wait_until(r1 + 2);
      btn_ni = 1'b0;
      p2 = cyc + LAT;
      push_exp("press2", p2, 5'b01100);
      wait_until(r1 + 20);
      btn_ni = 1'b1;
      r2 = cyc + LAT;
      push_exp("release2",   r2,            5'b00010);
      push_exp("hold2_last", r2 + HOLD - 1, 5'b00000);
      push_exp("hold2_rise", r2 + HOLD,     5'b10000);
      wait_until(r2 + HOLD + 5);

      // Async reset while PRESSED, button kept low, then long hold
      t = cyc;
      btn_ni = 1'b0;
      p = t + LAT;
      push_exp("press_pre_rst", p, 5'b01100);
      wait_until(p + 5);
      rst_ni = 1'b0;
      #1;
      checks++;
      assert (obs === 5'b00000) else begin
         errors++;
         $error("FAIL async_clear: observed=%b expected=00000", obs);
      end
      wait_until(cyc + 3);
      checks++;
      assert (obs === 5'b00000) else begin
         errors++;
         $error("FAIL in_reset: observed=%b expected=00000", obs);
      end
      rst_ni = 1'b1;
      t = cyc;
      p = t + LAT;
      push_exp("rst2_hold", t + HOLD, 5'b00000);
      push_exp("repress",   p,        5'b01100);
`ifdef BTN_RST_LONG_PRESS_EN
      push_exp("long", p + LP, 5'b01001);
`endif
      push_exp("held", p + 39, 5'b01000);
      wait_until(p + 40);
      btn_ni = 1'b1;
      r = cyc + LAT;
      push_exp("release3",   r,        5'b00010);
      push_exp("hold3_rise", r + HOLD, 5'b10000);
      wait_until(r + HOLD + 5);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain: observed=%0d pending expected=0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_btn_rst_conditioner
`default_nettype wire
